// File: rtl/acm_pkg.sv
// acm_pkg: shared constants and FSM state encodings for the ACM IN packetizer.
// Rev 1.0
`default_nettype none

package acm_pkg;

    localparam int ACM_MAX_PKT     = 64;
    localparam int ACM_DEF_TIMEOUT = 4800;

    localparam logic [0:0] ST_FILL  = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

endpackage

`default_nettype wire

// File: rtl/acm_pkt_buf.sv
// acm_pkt_buf: DEPTH x 8 simple dual-port RAM with a registered read port.
// Rev 1.0
`default_nettype none

module acm_pkt_buf
    import acm_pkg::*;
#(
    parameter int DEPTH = ACM_MAX_PKT,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Write-through on an address collision so a one-byte packet prefetches its own byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= 8'h00;
        end else if (we && (waddr == raddr)) begin
            rdata <= wdata;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

`default_nettype wire

// File: rtl/acm_in_packetizer.sv
// acm_in_packetizer: store-and-forward byte packetizer feeding the ACM IN pipe, Rev 1.0.
// Optional idle-timeout packet close: define ACM_PKTZ_TIMEOUT_EN.
`default_nettype none

module acm_in_packetizer
    import acm_pkg::*;
#(
    parameter int MAX_PKT = ACM_MAX_PKT,
    parameter int TIMEOUT = ACM_DEF_TIMEOUT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] i_data,
    input  logic       i_eop,
    input  logic       i_valid,
    output logic       i_ready,
    output logic [7:0] o_data,
    output logic       o_last,
    output logic       o_valid,
    input  logic       o_ready,
    output logic       o_flush_now,
    output logic       o_busy
);

    localparam int               CW   = $clog2(MAX_PKT + 1);
    localparam int               AW   = $clog2(MAX_PKT);
    localparam logic [CW-1:0]    FULL = CW'(MAX_PKT);

    if (MAX_PKT < 2 || TIMEOUT < 1) begin : g_bad_param
        $error("acm_in_packetizer: MAX_PKT must be >= 2 and TIMEOUT >= 1");
    end

    logic [0:0]    state;
    logic [0:0]    next_state;
    logic [CW-1:0] wr_cnt;
    logic [CW-1:0] rd_ptr;
    logic [CW-1:0] wr_cnt_inc;
    logic [AW-1:0] rd_next;
    logic [AW-1:0] raddr;
    logic          short_pkt;
    logic          accept;
    logic          handshake;
    logic          full_close;
    logic          eop_close;
    logic          timeout_close;

    assign accept     = i_valid & i_ready;
    assign handshake  = o_valid & o_ready;
    assign wr_cnt_inc = wr_cnt + CW'(1);
    assign rd_next    = rd_ptr[AW-1:0] + AW'(1);
    assign full_close = accept && (wr_cnt_inc == FULL);
    assign eop_close  = accept && i_eop && !full_close;

`ifdef ACM_PKTZ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] timer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (state != ST_FILL || accept || wr_cnt == '0) begin
            timer <= '0;
        end else if (timer != TW'(TIMEOUT)) begin
            timer <= timer + TW'(1);
        end
    end

    // Close on the idle cycle that brings the timer to TIMEOUT.
    assign timeout_close = (state == ST_FILL) && !accept && (wr_cnt != '0)
                           && (timer == TW'(TIMEOUT - 1));
`else
    assign timeout_close = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_FILL;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_FILL:  if (full_close || eop_close || timeout_close) next_state = ST_DRAIN;
            ST_DRAIN: if (handshake && o_last) next_state = ST_FILL;
            default:  next_state = ST_FILL;
        endcase
    end

    always_comb begin
        i_ready     = (state == ST_FILL);
        o_valid     = (state == ST_DRAIN);
        o_last      = (state == ST_DRAIN) && (rd_ptr == wr_cnt - CW'(1));
        o_flush_now = (state == ST_DRAIN) && short_pkt;
        o_busy      = (wr_cnt != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt    <= '0;
            rd_ptr    <= '0;
            short_pkt <= 1'b0;
        end else if (state == ST_FILL) begin
            if (accept) begin
                wr_cnt <= wr_cnt_inc;
            end
            if (full_close) begin
                short_pkt <= 1'b0;
            end else if (eop_close || timeout_close) begin
                short_pkt <= 1'b1;
            end
        end else if (handshake) begin
            if (o_last) begin
                wr_cnt    <= '0;
                rd_ptr    <= '0;
                short_pkt <= 1'b0;
            end else begin
                rd_ptr <= rd_ptr + CW'(1);
            end
        end
    end

    // Prefetch: address the byte that will be on o_data after this edge.
    always_comb begin
        raddr = '0;
        if (state == ST_DRAIN && !(handshake && o_last)) begin
            raddr = handshake ? rd_next : rd_ptr[AW-1:0];
        end
    end

    acm_pkt_buf #(
        .DEPTH (MAX_PKT),
        .AW    (AW)
    ) u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (accept),
        .waddr (wr_cnt[AW-1:0]),
        .wdata (i_data),
        .raddr (raddr),
        .rdata (o_data)
    );

endmodule

`default_nettype wire

// File: tb/tb_acm_in_packetizer.sv
// tb_acm_in_packetizer: directed self-checking bench for acm_in_packetizer.
// Rev 1.0
`default_nettype none

module tb_acm_in_packetizer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] i_data;
    logic       i_eop;
    logic       i_valid;
    logic       i_ready;
    logic [7:0] o_data;
    logic       o_last;
    logic       o_valid;
    logic       o_ready;
    logic       o_flush_now;
    logic       o_busy;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    acm_in_packetizer #(
        .MAX_PKT (64),
        .TIMEOUT (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_data      (i_data),
        .i_eop       (i_eop),
        .i_valid     (i_valid),
        .i_ready     (i_ready),
        .o_data      (o_data),
        .o_last      (o_last),
        .o_valid     (o_valid),
        .o_ready     (o_ready),
        .o_flush_now (o_flush_now),
        .o_busy      (o_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the byte is accepted.
    task automatic send_byte(input logic [7:0] d, input logic eop);
        check("i_ready_on_send", 32'(i_ready), 32'd1);
        i_data  = d;
        i_eop   = eop;
        i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        i_eop   = 1'b0;
    endtask

    // Consumes exp_q from the output port with o_ready asserted pct% of cycles.
    task automatic drain(input string tag, input int pct, input logic exp_flush);
        int         k       = 0;
        int         n       = exp_q.size();
        int         guard   = 0;
        logic       stalled = 1'b0;
        logic [7:0] held    = 8'h00;
        while (k < n && guard < 2000) begin
            guard++;
            if (stalled) begin
                check({tag, "_stall_valid"}, 32'(o_valid), 32'd1);
                check({tag, "_stall_data"}, 32'(o_data), 32'(held));
            end
            if (o_valid) begin
                check({tag, "_i_ready_low"}, 32'(i_ready), 32'd0);
                check({tag, "_flush"}, 32'(o_flush_now), 32'(exp_flush));
            end
            o_ready = ($urandom_range(0, 99) < pct);
            if (o_valid && o_ready) begin
                check({tag, "_data"}, 32'(o_data), 32'(exp_q[k]));
                check({tag, "_last"}, 32'(o_last), 32'(k == n - 1));
                k++;
                stalled = 1'b0;
            end else if (o_valid) begin
                stalled = 1'b1;
                held    = o_data;
            end
            @(negedge clk);
        end
        o_ready = 1'b0;
        check({tag, "_beats"}, 32'(k), 32'(n));
        check({tag, "_end_valid"}, 32'(o_valid), 32'd0);
        check({tag, "_end_ready"}, 32'(i_ready), 32'd1);
        check({tag, "_end_busy"}, 32'(o_busy), 32'd0);
        check({tag, "_end_flush"}, 32'(o_flush_now), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        rst_n   = 1'b0;
        i_data  = 8'h00;
        i_eop   = 1'b0;
        i_valid = 1'b0;
        o_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_o_valid", 32'(o_valid), 32'd0);
        check("rst_o_last", 32'(o_last), 32'd0);
        check("rst_i_ready", 32'(i_ready), 32'd1);
        check("rst_flush", 32'(o_flush_now), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_o_data", 32'(o_data), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Full packet, no eop.
        for (int i = 0; i < 64; i++) begin
            check("full_no_early_valid", 32'(o_valid), 32'd0);
            send_byte(8'(i), 1'b0);
            exp_q.push_back(8'(i));
        end
        check("full_valid_after_last", 32'(o_valid), 32'd1);
        check("full_busy", 32'(o_busy), 32'd1);
        drain("full", 100, 1'b0);

        // Short packet closed by eop.
        for (int i = 0; i < 5; i++) begin
            send_byte(8'(8'h41 + i), 1'(i == 4));
            exp_q.push_back(8'(8'h41 + i));
        end
        check("short_valid", 32'(o_valid), 32'd1);
        check("short_flush", 32'(o_flush_now), 32'd1);
        drain("short", 100, 1'b1);

        // Full packet under random backpressure.
        for (int i = 0; i < 64; i++) begin
            send_byte(8'((i * 7 + 3) & 8'hFF), 1'b0);
            exp_q.push_back(8'((i * 7 + 3) & 8'hFF));
        end
        drain("bp", 50, 1'b0);

        // eop on the filling byte is a full packet, not a short one.
        for (int i = 0; i < 64; i++) begin
            send_byte(8'(8'hC0 ^ i), 1'(i == 63));
            exp_q.push_back(8'(8'hC0 ^ i));
        end
        check("eop64_flush", 32'(o_flush_now), 32'd0);
        drain("eop64", 100, 1'b0);

        // Lone eop without a byte.
        i_eop = 1'b1;
        repeat (5) @(negedge clk);
        i_eop = 1'b0;
        check("lone_eop_valid", 32'(o_valid), 32'd0);
        check("lone_eop_busy", 32'(o_busy), 32'd0);

        // Idle partial packet.
        for (int i = 0; i < 3; i++) begin
            send_byte(8'(8'h70 + i), 1'b0);
            exp_q.push_back(8'(8'h70 + i));
        end
`ifdef ACM_PKTZ_TIMEOUT_EN
        repeat (15) @(negedge clk);
        check("tmo_not_yet", 32'(o_valid), 32'd0);
        @(negedge clk);
        check("tmo_valid", 32'(o_valid), 32'd1);
        check("tmo_flush", 32'(o_flush_now), 32'd1);
        drain("tmo", 100, 1'b1);
`else
        repeat (40) @(negedge clk);
        check("idle_no_valid", 32'(o_valid), 32'd0);
        check("idle_busy", 32'(o_busy), 32'd1);
        send_byte(8'h73, 1'b1);
        exp_q.push_back(8'h73);
        drain("idle", 100, 1'b1);
`endif

        // Asynchronous reset in the middle of DRAIN.
        for (int i = 0; i < 5; i++) begin
            send_byte(8'(8'h10 + i), 1'(i == 4));
        end
        o_ready = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(o_valid), 32'd0);
        check("mid_rst_ready", 32'(i_ready), 32'd1);
        check("mid_rst_busy", 32'(o_busy), 32'd0);
        check("mid_rst_flush", 32'(o_flush_now), 32'd0);
        check("mid_rst_last", 32'(o_last), 32'd0);
        o_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            send_byte(8'(8'h20 + i), 1'(i == 2));
            exp_q.push_back(8'(8'h20 + i));
        end
        drain("post_rst", 100, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
